// File: rtl/twi_master_pkg.sv
// twi_master_pkg: shared types and constants for the TWI master sequencer.
// Contents: sequencer state enum, TWSR[7:3] status codes, status width.
// Used by twi_master_control and twi_bus_timeout.
package twi_master_pkg;

  localparam int STATUS_WIDTH = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUS = 3'd1,
    S_START    = 3'd2,
    S_DATA     = 3'd3,
    S_ACK      = 3'd4,
    S_HOLD     = 3'd5,
    S_STOP     = 3'd6
  } state_e;

  localparam logic [STATUS_WIDTH-1:0] STAT_BUS_ERR   = 5'h00;
  localparam logic [STATUS_WIDTH-1:0] STAT_START     = 5'h01;
  localparam logic [STATUS_WIDTH-1:0] STAT_RSTART    = 5'h02;
  localparam logic [STATUS_WIDTH-1:0] STAT_SLAW_ACK  = 5'h03;
  localparam logic [STATUS_WIDTH-1:0] STAT_SLAW_NACK = 5'h04;
  localparam logic [STATUS_WIDTH-1:0] STAT_TX_ACK    = 5'h05;
  localparam logic [STATUS_WIDTH-1:0] STAT_TX_NACK   = 5'h06;
  localparam logic [STATUS_WIDTH-1:0] STAT_ARB_LOST  = 5'h07;
  localparam logic [STATUS_WIDTH-1:0] STAT_SLAR_ACK  = 5'h08;
  localparam logic [STATUS_WIDTH-1:0] STAT_SLAR_NACK = 5'h09;
  localparam logic [STATUS_WIDTH-1:0] STAT_RX_ACK    = 5'h0A;
  localparam logic [STATUS_WIDTH-1:0] STAT_RX_NACK   = 5'h0B;
  localparam logic [STATUS_WIDTH-1:0] STAT_NO_INFO   = 5'h1F;

endpackage

// File: rtl/twi_bus_timeout.sv
// twi_bus_timeout: counts half_scl ticks while the master waits for a busy bus.
// Ports: clk/reset, clear (hold count at zero), tick (half_scl), tc (count reached TIMEOUT_TICKS).
// tc is a registered-count decode; the count saturates at the terminal value.
module twi_bus_timeout #(
  parameter int                       TIMEOUT_WIDTH = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS = 16'd1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic tc
);

  logic [TIMEOUT_WIDTH-1:0] count_q, count_d;

  assign tc = (count_q == TIMEOUT_TICKS);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/twi_master_control.sv
// twi_master_control: master sequencing FSM driving the TWI bus interface unit from TWCR bits.
// Ports: TWCR bits + twint_clear in, BIU flags in; start/stop/data/ack enables, dirs, twint_set, twsto_clear, status out.
// All outputs registered from next state (1-cycle latency). Optional bus-wait timeout: TWI_BUS_TIMEOUT_EN.
module twi_master_control #(
  parameter int                       STATUS_WIDTH  = twi_master_pkg::STATUS_WIDTH,
  parameter int                       TIMEOUT_WIDTH = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS = 16'd1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    twen,
  input  logic                    twsta,
  input  logic                    twsto,
  input  logic                    twea,
  input  logic                    twint_clear,
  input  logic                    half_scl,
  input  logic                    bus_busy,
  input  logic                    start_complete,
  input  logic                    stop_complete,
  input  logic                    arbitration_lost,
  input  logic                    byte_transfer_complete,
  input  logic                    ack_transfer_complete,
  input  logic                    ack_bit,
  input  logic                    rw_bit,
  output logic                    start_en,
  output logic                    restart_en,
  output logic                    stop_en,
  output logic                    data_transfer_en,
  output logic                    ack_transfer_en,
  output logic                    data_transfer_dir,
  output logic                    ack_transfer_dir,
  output logic                    sla_sent,
  output logic                    master_mode,
  output logic                    twint_set,
  output logic                    twsto_clear,
  output logic [STATUS_WIDTH-1:0] status
);

  import twi_master_pkg::*;

  state_e state_q, state_d;
  logic   sla_phase_q, sla_phase_d;
  logic   restart_q, restart_d;       // current START was entered from HOLD
  logic   twea_q, twea_d;
  logic   byte_prev_q, byte_prev_d;
  logic   sla_sent_q, sla_sent_d;
  logic   twint_set_q, twint_set_d;
  logic   twsto_clear_q, twsto_clear_d;
  logic [STATUS_WIDTH-1:0] status_q, status_d;
  logic   start_en_q, restart_en_q, stop_en_q, data_en_q, ack_en_q;
  logic   data_dir_q, ack_dir_q, master_mode_q;
  logic   drv, we_drive, byte_rise, timeout_tc;

`ifdef TWI_BUS_TIMEOUT_EN
  // Count is held at zero outside WAIT_BUS, so every entry starts fresh.
  twi_bus_timeout #(
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_bus_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != S_WAIT_BUS),
    .tick  (half_scl),
    .tc    (timeout_tc)
  );
`else
  logic timeout_unused;
  assign timeout_unused = half_scl ^ (^TIMEOUT_TICKS);
  assign timeout_tc     = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    sla_phase_d   = sla_phase_q;
    restart_d     = restart_q;
    twea_d        = twea_q;
    byte_prev_d   = byte_transfer_complete;
    sla_sent_d    = sla_sent_q;
    twint_set_d   = 1'b0;
    twsto_clear_d = 1'b0;
    status_d      = status_q;
    // The address byte is always sent by the master; data direction follows R/W.
    drv       = sla_phase_q | ~rw_bit;
    we_drive  = ((state_q == S_DATA) && drv) || ((state_q == S_ACK) && !drv);
    byte_rise = byte_transfer_complete & ~byte_prev_q;

    if (twint_clear && ((state_q == S_IDLE) || (state_q == S_HOLD))) begin
      twea_d = twea;
    end

    if (!twen) begin
      state_d     = S_IDLE;
      status_d    = STATUS_WIDTH'(STAT_NO_INFO);
      sla_sent_d  = 1'b0;
      sla_phase_d = 1'b0;
      restart_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (twint_clear && twsta) begin
            restart_d = 1'b0;
            if (bus_busy) begin
              state_d = S_WAIT_BUS;
            end else begin
              state_d     = S_START;
              sla_phase_d = 1'b1;
            end
          end else if (twint_clear && twsto) begin
            twsto_clear_d = 1'b1;
          end
        end
        S_WAIT_BUS: begin
          if (!bus_busy) begin
            state_d     = S_START;
            sla_phase_d = 1'b1;
          end else if (timeout_tc) begin
            state_d     = S_IDLE;
            status_d    = STATUS_WIDTH'(STAT_BUS_ERR);
            twint_set_d = 1'b1;
          end
        end
        S_START: begin
          if (start_complete) begin
            state_d     = S_HOLD;
            twint_set_d = 1'b1;
            status_d    = restart_q ? STATUS_WIDTH'(STAT_RSTART) : STATUS_WIDTH'(STAT_START);
          end
        end
        S_HOLD: begin
          if (twint_clear) begin
            if (twsto) begin
              state_d = S_STOP;
            end else if (twsta) begin
              state_d     = S_START;
              restart_d   = 1'b1;
              sla_phase_d = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (arbitration_lost && we_drive) begin
            state_d     = S_IDLE;
            status_d    = STATUS_WIDTH'(STAT_ARB_LOST);
            twint_set_d = 1'b1;
            sla_phase_d = 1'b0;
          end else if (byte_rise) begin
            state_d = S_ACK;
          end
        end
        S_ACK: begin
          if (arbitration_lost && we_drive) begin
            state_d     = S_IDLE;
            status_d    = STATUS_WIDTH'(STAT_ARB_LOST);
            twint_set_d = 1'b1;
            sla_phase_d = 1'b0;
          end else if (ack_transfer_complete) begin
            state_d     = S_HOLD;
            twint_set_d = 1'b1;
            sla_sent_d  = 1'b1;
            sla_phase_d = 1'b0;
            case ({sla_phase_q, rw_bit})
              2'b10:   status_d = ack_bit ? STATUS_WIDTH'(STAT_SLAW_NACK) : STATUS_WIDTH'(STAT_SLAW_ACK);
              2'b00:   status_d = ack_bit ? STATUS_WIDTH'(STAT_TX_NACK)   : STATUS_WIDTH'(STAT_TX_ACK);
              2'b11:   status_d = ack_bit ? STATUS_WIDTH'(STAT_SLAR_NACK) : STATUS_WIDTH'(STAT_SLAR_ACK);
              default: status_d = twea_q  ? STATUS_WIDTH'(STAT_RX_ACK)    : STATUS_WIDTH'(STAT_RX_NACK);
            endcase
          end
        end
        S_STOP: begin
          if (stop_complete) begin
            state_d       = S_IDLE;
            twsto_clear_d = 1'b1;
            status_d      = STATUS_WIDTH'(STAT_NO_INFO);
            sla_sent_d    = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sla_phase_q   <= 1'b0;
      restart_q     <= 1'b0;
      twea_q        <= 1'b0;
      byte_prev_q   <= 1'b0;
      sla_sent_q    <= 1'b0;
      twint_set_q   <= 1'b0;
      twsto_clear_q <= 1'b0;
      status_q      <= STATUS_WIDTH'(STAT_NO_INFO);
      start_en_q    <= 1'b0;
      restart_en_q  <= 1'b0;
      stop_en_q     <= 1'b0;
      data_en_q     <= 1'b0;
      ack_en_q      <= 1'b0;
      data_dir_q    <= 1'b0;
      ack_dir_q     <= 1'b0;
      master_mode_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sla_phase_q   <= sla_phase_d;
      restart_q     <= restart_d;
      twea_q        <= twea_d;
      byte_prev_q   <= byte_prev_d;
      sla_sent_q    <= sla_sent_d;
      twint_set_q   <= twint_set_d;
      twsto_clear_q <= twsto_clear_d;
      status_q      <= status_d;
      // Moore decodes of the next state, so enables appear one edge after the trigger.
      start_en_q    <= (state_d == S_START);
      restart_en_q  <= (state_d == S_START) && restart_d;
      stop_en_q     <= (state_d == S_STOP);
      data_en_q     <= (state_d == S_DATA);
      ack_en_q      <= (state_d == S_ACK);
      data_dir_q    <= ((state_d == S_DATA) || (state_d == S_ACK)) && (sla_phase_d | ~rw_bit);
      ack_dir_q     <= (state_d == S_ACK) && !(sla_phase_d | ~rw_bit);
      master_mode_q <= (state_d != S_IDLE) && (state_d != S_WAIT_BUS);
    end
  end

  assign start_en          = start_en_q;
  assign restart_en        = restart_en_q;
  assign stop_en           = stop_en_q;
  assign data_transfer_en  = data_en_q;
  assign ack_transfer_en   = ack_en_q;
  assign data_transfer_dir = data_dir_q;
  assign ack_transfer_dir  = ack_dir_q;
  assign sla_sent          = sla_sent_q;
  assign master_mode       = master_mode_q;
  assign twint_set         = twint_set_q;
  assign twsto_clear       = twsto_clear_q;
  assign status            = status_q;

endmodule

// File: tb/tb_twi_master_control.sv
// tb_twi_master_control: directed bench for the TWI master sequencer.
// Drives inputs 1 ns after the rising edge and checks outputs at that point, one edge later.
// Timeout scenario runs only when TWI_BUS_TIMEOUT_EN is defined.
module tb_twi_master_control;

  logic clk = 1'b0;
  logic reset;
  logic twen, twsta, twsto, twea, twint_clear, half_scl, bus_busy;
  logic start_complete, stop_complete, arbitration_lost;
  logic byte_transfer_complete, ack_transfer_complete, ack_bit, rw_bit;
  logic start_en, restart_en, stop_en, data_transfer_en, ack_transfer_en;
  logic data_transfer_dir, ack_transfer_dir, sla_sent, master_mode, twint_set, twsto_clear;
  logic [4:0] status;

  int vectors = 0;
  int miscompares = 0;

  // Output bit positions in the packed observation word.
  localparam logic [10:0] O_START = 11'h400;
  localparam logic [10:0] O_RST   = 11'h200;
  localparam logic [10:0] O_STOP  = 11'h100;
  localparam logic [10:0] O_DEN   = 11'h080;
  localparam logic [10:0] O_AEN   = 11'h040;
  localparam logic [10:0] O_DDIR  = 11'h020;
  localparam logic [10:0] O_ADIR  = 11'h010;
  localparam logic [10:0] O_SLA   = 11'h008;
  localparam logic [10:0] O_M     = 11'h004;
  localparam logic [10:0] O_TS    = 11'h002;
  localparam logic [10:0] O_TSC   = 11'h001;

  always #5 clk = ~clk;

  twi_master_control dut (
    .clk                    (clk),
    .reset                  (reset),
    .twen                   (twen),
    .twsta                  (twsta),
    .twsto                  (twsto),
    .twea                   (twea),
    .twint_clear            (twint_clear),
    .half_scl               (half_scl),
    .bus_busy               (bus_busy),
    .start_complete         (start_complete),
    .stop_complete          (stop_complete),
    .arbitration_lost       (arbitration_lost),
    .byte_transfer_complete (byte_transfer_complete),
    .ack_transfer_complete  (ack_transfer_complete),
    .ack_bit                (ack_bit),
    .rw_bit                 (rw_bit),
    .start_en               (start_en),
    .restart_en             (restart_en),
    .stop_en                (stop_en),
    .data_transfer_en       (data_transfer_en),
    .ack_transfer_en        (ack_transfer_en),
    .data_transfer_dir      (data_transfer_dir),
    .ack_transfer_dir       (ack_transfer_dir),
    .sla_sent               (sla_sent),
    .master_mode            (master_mode),
    .twint_set              (twint_set),
    .twsto_clear            (twsto_clear),
    .status                 (status)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [10:0] exp_o, input logic [4:0] exp_s);
    logic [15:0] obs, expv;
    obs  = {start_en, restart_en, stop_en, data_transfer_en, ack_transfer_en,
            data_transfer_dir, ack_transfer_dir, sla_sent, master_mode, twint_set,
            twsto_clear, status};
    expv = {exp_o, exp_s};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, expv);
    end
  endtask

  initial begin
    reset = 1'b1; twen = 1'b0; twsta = 1'b0; twsto = 1'b0; twea = 1'b0;
    twint_clear = 1'b0; half_scl = 1'b0; bus_busy = 1'b0;
    start_complete = 1'b0; stop_complete = 1'b0; arbitration_lost = 1'b0;
    byte_transfer_complete = 1'b0; ack_transfer_complete = 1'b0;
    ack_bit = 1'b0; rw_bit = 1'b0;
    #3;
    check("reset", 11'h000, 5'h1F);
    step(); step();
    reset = 1'b0; twen = 1'b1;
    step();
    check("idle", 11'h000, 5'h1F);

    // START on an idle bus
    twint_clear = 1'b1; twsta = 1'b1; step(); twint_clear = 1'b0; twsta = 1'b0;
    check("start_en", O_START | O_M, 5'h1F);
    step();
    check("start_wait", O_START | O_M, 5'h1F);
    start_complete = 1'b1; step(); start_complete = 1'b0;
    check("start_done", O_M | O_TS, 5'h01);
    step();
    check("start_hold", O_M, 5'h01);

    // SLA+W, ACKed
    twint_clear = 1'b1; rw_bit = 1'b0; step(); twint_clear = 1'b0;
    check("slaw_data", O_DEN | O_DDIR | O_M, 5'h01);
    byte_transfer_complete = 1'b1; step();
    check("slaw_ack", O_AEN | O_DDIR | O_M, 5'h01);
    ack_transfer_complete = 1'b1; ack_bit = 1'b0; step();
    ack_transfer_complete = 1'b0; byte_transfer_complete = 1'b0;
    check("slaw_acked", O_SLA | O_M | O_TS, 5'h03);
    step();
    check("slaw_hold", O_SLA | O_M, 5'h03);

    // Data TX, NACKed; byte flag already high on entry must wait for a fresh rise
    byte_transfer_complete = 1'b1;
    twint_clear = 1'b1; rw_bit = 1'b0; step(); twint_clear = 1'b0;
    check("tx_data", O_DEN | O_DDIR | O_SLA | O_M, 5'h03);
    step();
    check("tx_level_high", O_DEN | O_DDIR | O_SLA | O_M, 5'h03);
    byte_transfer_complete = 1'b0; step();
    check("tx_level_low", O_DEN | O_DDIR | O_SLA | O_M, 5'h03);
    byte_transfer_complete = 1'b1; step();
    check("tx_ack", O_AEN | O_DDIR | O_SLA | O_M, 5'h03);
    ack_transfer_complete = 1'b1; ack_bit = 1'b1; step();
    ack_transfer_complete = 1'b0; byte_transfer_complete = 1'b0; ack_bit = 1'b0;
    check("tx_nack", O_SLA | O_M | O_TS, 5'h06);

    // Data RX with twea=0
    twint_clear = 1'b1; twea = 1'b0; rw_bit = 1'b1; step(); twint_clear = 1'b0;
    check("rx_data", O_DEN | O_SLA | O_M, 5'h06);
    byte_transfer_complete = 1'b1; step();
    check("rx_ack", O_AEN | O_ADIR | O_SLA | O_M, 5'h06);
    ack_transfer_complete = 1'b1; ack_bit = 1'b1; step();
    ack_transfer_complete = 1'b0; byte_transfer_complete = 1'b0; ack_bit = 1'b0;
    check("rx_nack", O_SLA | O_M | O_TS, 5'h0B);

    // Arbitration lost together with ack completion while master drives ACK
    twint_clear = 1'b1; twea = 1'b1; rw_bit = 1'b1; step(); twint_clear = 1'b0;
    check("arb_data", O_DEN | O_SLA | O_M, 5'h0B);
    byte_transfer_complete = 1'b1; step();
    check("arb_ack", O_AEN | O_ADIR | O_SLA | O_M, 5'h0B);
    ack_transfer_complete = 1'b1; arbitration_lost = 1'b1; step();
    ack_transfer_complete = 1'b0; arbitration_lost = 1'b0; byte_transfer_complete = 1'b0;
    check("arb_lost", O_SLA | O_TS, 5'h07);
    step();
    check("arb_idle", O_SLA, 5'h07);

    // Busy bus, then START, repeated START, STOP
    bus_busy = 1'b1; twint_clear = 1'b1; twsta = 1'b1; rw_bit = 1'b0; step();
    twint_clear = 1'b0; twsta = 1'b0;
    check("wait_bus", O_SLA, 5'h07);
    step();
    check("wait_busy", O_SLA, 5'h07);
    bus_busy = 1'b0; step();
    check("bus_free", O_START | O_SLA | O_M, 5'h07);
    start_complete = 1'b1; step(); start_complete = 1'b0;
    check("start2_done", O_SLA | O_M | O_TS, 5'h01);
    twint_clear = 1'b1; twsta = 1'b1; step(); twint_clear = 1'b0; twsta = 1'b0;
    check("rstart_en", O_START | O_RST | O_SLA | O_M, 5'h01);
    start_complete = 1'b1; step(); start_complete = 1'b0;
    check("rstart_done", O_SLA | O_M | O_TS, 5'h02);
    twint_clear = 1'b1; twsta = 1'b1; twsto = 1'b1; step();
    twint_clear = 1'b0; twsta = 1'b0; twsto = 1'b0;
    check("stop_en", O_STOP | O_SLA | O_M, 5'h02);
    stop_complete = 1'b1; step(); stop_complete = 1'b0;
    check("stop_done", O_TSC, 5'h1F);
    step();
    check("stopped", 11'h000, 5'h1F);

    // STOP request while idle
    twint_clear = 1'b1; twsto = 1'b1; step(); twint_clear = 1'b0; twsto = 1'b0;
    check("idle_twsto", O_TSC, 5'h1F);
    step();
    check("idle_twsto_end", 11'h000, 5'h1F);

    // twen drop beats a byte completion in DATA
    twint_clear = 1'b1; twsta = 1'b1; step(); twint_clear = 1'b0; twsta = 1'b0;
    start_complete = 1'b1; step(); start_complete = 1'b0;
    check("twen_pre_hold", O_M | O_TS, 5'h01);
    twint_clear = 1'b1; step(); twint_clear = 1'b0;
    check("twen_pre_data", O_DEN | O_DDIR | O_M, 5'h01);
    twen = 1'b0; byte_transfer_complete = 1'b1; step();
    twen = 1'b1; byte_transfer_complete = 1'b0;
    check("twen_off", 11'h000, 5'h1F);

    // Asynchronous reset mid-transfer
    twint_clear = 1'b1; twsta = 1'b1; step(); twint_clear = 1'b0; twsta = 1'b0;
    start_complete = 1'b1; step(); start_complete = 1'b0;
    check("areset_pre", O_M | O_TS, 5'h01);
    #2 reset = 1'b1;
    #1 check("async_reset", 11'h000, 5'h1F);
    step();
    reset = 1'b0;
    step();

`ifdef TWI_BUS_TIMEOUT_EN
    bus_busy = 1'b1; twint_clear = 1'b1; twsta = 1'b1; step();
    twint_clear = 1'b0; twsta = 1'b0;
    for (int i = 0; i < 999; i++) begin
      half_scl = 1'b1; step();
      half_scl = 1'b0; step();
    end
    check("timeout_pending", 11'h000, 5'h1F);
    half_scl = 1'b1; step();
    half_scl = 1'b0; step();
    check("timeout", O_TS, 5'h00);
    step();
    check("timeout_idle", 11'h000, 5'h00);
    bus_busy = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/twi_master_control.md
# twi_master_control

Master sequencing FSM for the APB TWI controller. It sits directly upstream of the bus interface unit. From the TWCR control bits and the software "go" pulse it drives the start, stop, data and ack enables and directions. It consumes the unit's completion, arbitration and ack flags, and produces the TWSR status code and the TWINT set pulse.

## Interface
- STATUS_WIDTH, 5, width of the status code (TWSR[7:3])
- TIMEOUT_WIDTH, 16, width of the bus-wait timeout counter
- TIMEOUT_TICKS, 16'd1000, number of half_scl ticks allowed in WAIT_BUS
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- twen  in  1  TWI enable
- twsta, twsto, twea  in  1  TWCR control bits, sampled on twint_clear
- twint_clear  in  1  1-cycle pulse: software wrote TWINT=1
- half_scl  in  1  half-SCL-period tick
- bus_busy, start_complete, stop_complete, arbitration_lost  in  1  bus interface unit flags
- byte_transfer_complete, ack_transfer_complete  in  1  bus interface unit level flags
- ack_bit  in  1  sampled ack; 0 = ACK
- rw_bit  in  1  latched R/W bit of the SLA byte; 1 = read
- start_en, restart_en, stop_en  out  1  start/stop generator controls
- data_transfer_en, ack_transfer_en  out  1  phase enables
- data_transfer_dir, ack_transfer_dir  out  1  1 = this master drives SDA
- sla_sent  out  1  address byte has been completed
- master_mode  out  1  master owns SCL
- twint_set  out  1  1-cycle pulse: set TWINT
- twsto_clear  out  1  1-cycle pulse: clear TWSTO
- status  out  STATUS_WIDTH  TWSR[7:3]

## Operation
States: IDLE, WAIT_BUS, START, DATA, ACK, HOLD, STOP. The `sla_phase` flag is set on entry to START and cleared at the end of the first ACK.

- **IDLE:** all enables 0, master_mode=0.
  - twint_clear & twen & twsta: go to WAIT_BUS if bus_busy, else START.
  - twint_clear & twsto & ~twsta: pulse twsto_clear and stay in IDLE.
- **WAIT_BUS:** go to START when ~bus_busy.
- **START:** master_mode=1 from START onward; start_en=1. restart_en=1 if START was entered from HOLD. On start_complete:
  - status=01 (START) or 02 (repeated START);
  - pulse twint_set; go to HOLD.
- **HOLD:** enables 0, master_mode=1. On twint_clear, priority is twsto > twsta > data:
  - twsto: go to STOP.
  - twsta: go to START.
  - otherwise: go to DATA.
- **DATA:** data_transfer_en=1. data_transfer_dir = sla_phase | ~rw_bit. On the rising edge of byte_transfer_complete (registered previous value), go to ACK.
- **ACK:** ack_transfer_en=1, ack_transfer_dir = ~data_transfer_dir. On ack_transfer_complete, pulse twint_set, go to HOLD, set sla_sent=1, and load status:
  - SLA+W: 03 (ACK) / 04 (NACK)
  - data TX: 05 / 06
  - SLA+R: 08 / 09
  - data RX: 0A (twea=1) / 0B (twea=0)
- **STOP:** stop_en=1. On stop_complete: pulse twsto_clear, status=1F, clear sla_sent, go to IDLE. No twint_set.
- **Arbitration lost** in DATA or ACK while the master drives SDA: status=07, pulse twint_set, master_mode=0, go to IDLE.
- **twen=0** in any state: go to IDLE next edge, status=1F, no pulses.
- **Simultaneous events:**
  - arbitration_lost wins over ack_transfer_complete and byte_transfer_complete.
  - twen=0 wins over everything.
- **twint_clear** outside IDLE and HOLD is ignored.

## Timing
- **Reset values:** state IDLE; all enables, master_mode, sla_sent, twint_set and twsto_clear = 0; status=5'h1F.
- **Output registration:** all outputs are registered Moore decodes of state. twint_set and status update on the same edge as the transition into HOLD.
- **Latency:**
  - twint_clear to first enable: 1 cycle.
  - completion flag to twint_set: 1 cycle.
- **Pulse width:** twint_set and twsto_clear are exactly 1 cycle.
- **Reset mid-transfer:** asynchronous; all outputs return to reset values immediately.

## Configuration
- TWI_BUS_TIMEOUT_EN defined:
  - WAIT_BUS counts half_scl ticks.
  - When the count reaches TIMEOUT_TICKS: status=00 (bus error), pulse twint_set, go to IDLE.
  - The counter clears on WAIT_BUS entry.
- Not defined: WAIT_BUS waits indefinitely. No counter logic is present.

## Structure
- **Package twi_master_pkg:**
  - state enum;
  - status code localparams (01–0B, 00, 1F);
  - STATUS_WIDTH.
- **Sub-module twi_bus_timeout:** half_scl-tick counter with clear and terminal-count outputs. Instantiated only under TWI_BUS_TIMEOUT_EN.

## Test plan
- Idle bus, twsta+twint_clear:
  - start_en high next cycle;
  - start_complete then gives status=01 and one twint_set pulse.
- SLA+W phase, ack_transfer_complete with ack_bit=0: status=03, sla_sent=1, state HOLD.
- rw_bit=1 data byte with twea=0: data_transfer_dir=0, ack_transfer_dir=1, final status=0B.
- arbitration_lost in the same cycle as ack_transfer_complete: status=07, master_mode=0, IDLE.
- HOLD with twsto+twint_clear: stop_en set, stop_complete gives twsto_clear pulse, status=1F, no twint_set.
- TWI_BUS_TIMEOUT_EN, bus_busy held high for 1000 half_scl ticks: status=00, twint_set, IDLE.
